nios_ii_system_debounced_pio: RTL and testbench

//  Avalon-MM slave PIO for N push-button/switch inputs: 2-FF sync, per-channel debounce,
//  per-bit rising/falling edge select, W1C edge capture, masked level IRQ to the Nios II.

---
 rtl/nios_ii_system_debounced_pio_if.sv | 19 +
 rtl/nios_ii_system_debounced_pio.sv | 121 ++++++++++++
 tb/tb_nios_ii_system_debounced_pio.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/nios_ii_system_debounced_pio_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO: register access plus level IRQ.
interface nios_ii_system_debounced_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/nios_ii_system_debounced_pio.sv
// Debounced input PIO for push-buttons/switches: 2-FF synchroniser, per-channel
// debounce counter, per-bit rise/fall edge select, W1C edge capture and masked IRQ.
module nios_ii_system_debounced_pio #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1,
    parameter logic [WIDTH-1:0] RISE_EN_RESET   = '0,
    parameter logic [WIDTH-1:0] FALL_EN_RESET   = '1
) (
    input logic                         clk,
    input logic                         reset,
    nios_ii_system_debounced_pio_if.slave avs,
    input logic [WIDTH-1:0]             in_port
);
    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] edge_set;
    logic             unused_wdata;

    assign wr_en        = avs.chipselect & ~avs.write_n;
    assign wdata        = avs.writedata[WIDTH-1:0];
    assign unused_wdata = ^avs.writedata;

    // Synchroniser and per-bit debounce: a bit is accepted only after it has
    // differed from the stable value for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        sync1_d  = in_port;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '{default: '0};
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Edge events are derived from the upcoming stable update so capture lands
    // on the same edge; enables are the registered values, so a write to them
    // only affects flips after it has taken effect.
    always_comb begin
        edge_set = (stable_q & ~stable_d & fall_en_q) | (~stable_q & stable_d & rise_en_q);
    end

    // Register writes; W1C clear on the capture register, a coincident set wins.
    always_comb begin
        irq_mask_d     = irq_mask_q;
        rise_en_d      = rise_en_q;
        fall_en_d      = fall_en_q;
        edge_capture_d = edge_capture_q | edge_set;
        if (wr_en) begin
            case (avs.address)
                3'd2:    irq_mask_d     = wdata;
                3'd3:    edge_capture_d = (edge_capture_q & ~wdata) | edge_set;
                3'd4:    rise_en_d      = wdata;
                3'd5:    fall_en_d      = wdata;
                default: ;
            endcase
        end
    end

    // Read mux, registered every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (avs.address)
            3'd0:    readdata_d[WIDTH-1:0] = stable_q;
            3'd1:    readdata_d[WIDTH-1:0] = sync2_q;
            3'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            3'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
            3'd4:    readdata_d[WIDTH-1:0] = rise_en_q;
            3'd5:    readdata_d[WIDTH-1:0] = fall_en_q;
            default: readdata_d = '0;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q        <= IDLE_LEVEL;
            sync2_q        <= IDLE_LEVEL;
            stable_q       <= IDLE_LEVEL;
            cnt_q          <= '{default: '0};
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            rise_en_q      <= RISE_EN_RESET;
            fall_en_q      <= FALL_EN_RESET;
            readdata_q     <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            stable_q       <= stable_d;
            cnt_q          <= cnt_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            rise_en_q      <= rise_en_d;
            fall_en_q      <= fall_en_d;
            readdata_q     <= readdata_d;
        end
    end

    assign avs.readdata = readdata_q;
    assign avs.irq      = |(edge_capture_q & irq_mask_q);
endmodule

// File: tb/tb_nios_ii_system_debounced_pio.sv
// Bench for the debounced PIO: vector table of bus/input operations, reads scored
// through an expected-value queue, plus a hand-written mid-debounce reset sequence.
module tb_nios_ii_system_debounced_pio;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_port;

    nios_ii_system_debounced_pio_if bus ();

    nios_ii_system_debounced_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .avs     (bus),
        .in_port (in_port)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {OP_IN, OP_WAIT, OP_WR, OP_RD} op_e;

    typedef struct {
        op_e         op;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        logic        exp_irq;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        logic        exp_irq;
        logic [2:0]  addr;
        int          idx;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   tests  = 0;
    int   failed = 0;

    function automatic void add(op_e op, logic [2:0] a, logic [31:0] d, logic [31:0] e, logic ei);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.exp = e; v.exp_irq = ei;
        vecs.push_back(v);
    endfunction

    function automatic void inp(logic [3:0] v);         add(OP_IN, 3'd0, {28'd0, v}, 32'd0, 1'b0); endfunction
    function automatic void wt(int n);                  add(OP_WAIT, 3'd0, 32'(n), 32'd0, 1'b0);   endfunction
    function automatic void wr(logic [2:0] a, logic [31:0] d) ; add(OP_WR, a, d, 32'd0, 1'b0);     endfunction
    function automatic void rd(logic [2:0] a, logic [31:0] e, logic ei); add(OP_RD, a, 32'd0, e, ei); endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pop the oldest expected read and compare it against what the DUT produced.
    task automatic score();
        sb_t s;
        if (sb.size() == 0) begin
            tests++; failed++;
            $display("FAIL scoreboard: empty at time %0t, got %h, expected an entry", $time, bus.readdata);
        end else begin
            s = sb.pop_front();
            check($sformatf("vec%0d rd addr%0d", s.idx, s.addr), bus.readdata, s.exp);
            check($sformatf("vec%0d irq", s.idx), {31'd0, bus.irq}, {31'd0, s.exp_irq});
        end
    endtask

    task automatic do_read(logic [2:0] a, logic [31:0] e, logic ei, int idx);
        sb_t s;
        bus.address = a;
        s.exp = e; s.exp_irq = ei; s.addr = a; s.idx = idx;
        sb.push_back(s);
        @(posedge clk); #1;
        score();
        @(negedge clk);
    endtask

    task automatic do_write(logic [2:0] a, logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and read latency.
        rd(0, 32'hF, 0); rd(1, 32'hF, 0); rd(2, 0, 0); rd(3, 0, 0);
        rd(4, 0, 0); rd(5, 32'hF, 0); rd(6, 0, 0); rd(7, 0, 0);
        // Short glitch rejected.
        inp(4'hE); wt(4); inp(4'hF); wt(10); rd(0, 32'hF, 0); rd(3, 0, 0);
        // Accepted press: capture appears exactly 2+8 edges after the input step.
        wr(2, 1); rd(2, 1, 0);
        inp(4'hE); wt(8); rd(3, 0, 1); rd(3, 1, 1); rd(0, 32'hE, 1); rd(1, 32'hE, 1);
        wr(2, 0); rd(3, 1, 0); wr(3, 1); rd(3, 0, 0);
        inp(4'hF); wt(12); rd(3, 0, 0); rd(0, 32'hF, 0);
        inp(4'hE); wt(12); rd(3, 1, 0); wr(2, 1); rd(3, 1, 1);
        // W1C and set-wins collision.
        inp(4'hC); wt(12); rd(3, 3, 1); wr(3, 1); rd(3, 2, 0); wr(3, 32'hF); rd(3, 0, 0);
        inp(4'hF); wt(12); rd(3, 0, 0); rd(0, 32'hF, 0);
        inp(4'hD); wt(12); rd(3, 2, 0);
        inp(4'hF); wt(12); rd(3, 2, 0);
        inp(4'hD); wt(8); wr(3, 2); rd(3, 2, 0); wt(4); rd(0, 32'hD, 0);
        // Rise/fall enables.
        wr(3, 32'hF); rd(3, 0, 0); wr(4, 2); rd(4, 2, 0);
        inp(4'hF); wt(12); rd(3, 2, 0); wr(3, 32'hF);
        inp(4'hD); wt(12); rd(3, 2, 0); wr(3, 32'hF);
        wr(5, 0); rd(5, 0, 0);
        inp(4'hF); wt(12); rd(3, 2, 0); wr(3, 32'hF);
        inp(4'hD); wt(12); rd(3, 0, 0);
        inp(4'hF); wt(12); rd(3, 2, 0); wr(3, 32'hF); rd(3, 0, 0);
        // Read-only/unused addresses, upper bits zero.
        wr(0, 0); rd(0, 32'hF, 0); wr(6, 32'hFFFF); rd(6, 0, 0);
        wr(2, 32'hFFFF_FFFF); rd(2, 32'hF, 0);
        // Non-reset config before the reset test.
        wr(4, 32'hF); wr(5, 0); rd(5, 0, 0);

        reset          = 1'b1;
        in_port        = 4'hF;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset readdata", bus.readdata, 32'd0);
        check("reset irq", {31'd0, bus.irq}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_IN:   begin in_port = vecs[i].data[3:0]; @(negedge clk); end
                OP_WAIT: repeat (int'(vecs[i].data)) @(negedge clk);
                OP_WR:   do_write(vecs[i].addr, vecs[i].data);
                OP_RD:   do_read(vecs[i].addr, vecs[i].exp, vecs[i].exp_irq, i);
                default: ;
            endcase
        end

        // Reset while bit0 count is at 5: count discarded, then re-accepted 10 cycles later.
        in_port = 4'hE;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid reset readdata", bus.readdata, 32'd0);
        check("mid reset irq", {31'd0, bus.irq}, 32'd0);
        for (int k = 8; k < 20; k++) begin
            do_read(3'd0, (k >= 18) ? 32'hE : 32'hF, 1'b0, 1000 + k);
        end
        do_read(3'd2, 32'd0, 1'b0, 2000);
        do_read(3'd4, 32'd0, 1'b0, 2001);
        do_read(3'd5, 32'hF, 1'b0, 2002);
        do_read(3'd3, 32'h1, 1'b0, 2003);

        if (sb.size() != 0) begin
            tests++; failed++;
            $display("FAIL scoreboard drain: %0d left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
